// File: rtl/pkt_rr_fifo_arbiter.sv
// Packet-granular round-robin arbiter: drains NUM_QUEUES fallthrough FIFOs into one
// registered output stream, holding each grant until the packet's EOP word has moved.
module pkt_rr_fifo_arbiter #(
    parameter int NUM_QUEUES = 4,
    parameter int QUEUE_BITS = $clog2(NUM_QUEUES),
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
    input  logic [NUM_QUEUES-1:0]            in_empty,
    output logic [NUM_QUEUES-1:0]            in_rd_en,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    output logic [QUEUE_BITS-1:0]            cur_queue,
    output logic                             busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [QUEUE_BITS-1:0] r_cur_queue;
    logic [QUEUE_BITS-1:0] w_cur_queue_next;
    logic [QUEUE_BITS-1:0] r_rr_ptr;
    logic [QUEUE_BITS-1:0] w_rr_ptr_next;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [CTRL_WIDTH-1:0] r_out_ctrl;
    logic                  r_out_wr;

    logic [DATA_WIDTH-1:0] w_q_data [NUM_QUEUES];
    logic [CTRL_WIDTH-1:0] w_q_ctrl [NUM_QUEUES];
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [CTRL_WIDTH-1:0] w_sel_ctrl;
    logic                  w_sel_empty;
    logic                  w_sel_is_ctrl;
    logic                  w_granted;
    logic                  w_xfer;
    logic                  w_found;
    logic [QUEUE_BITS-1:0] w_grant_idx;
    logic [QUEUE_BITS-1:0] w_search_idx;

    // Unpack the flat FIFO buses and decode the one-hot pop for the granted queue.
    generate
        for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_queue
            assign w_q_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_q_ctrl[gi] = in_ctrl[gi*CTRL_WIDTH +: CTRL_WIDTH];
            assign in_rd_en[gi] = w_xfer && (r_cur_queue == QUEUE_BITS'(gi));
        end
    endgenerate

    assign w_sel_data    = w_q_data[r_cur_queue];
    assign w_sel_ctrl    = w_q_ctrl[r_cur_queue];
    assign w_sel_empty   = in_empty[r_cur_queue];
    assign w_sel_is_ctrl = |w_sel_ctrl;
    assign w_granted     = (r_state != ST_IDLE);
    assign w_xfer        = w_granted && !w_sel_empty && out_rdy;

    // Round-robin search starting at r_rr_ptr. Walking offsets from highest to lowest
    // lets the smallest offset win; the index wraps for free since NUM_QUEUES is 2^n.
    always_comb begin
        w_found      = 1'b0;
        w_grant_idx  = r_rr_ptr;
        w_search_idx = r_rr_ptr;
        for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
            w_search_idx = r_rr_ptr + QUEUE_BITS'(k);
            if (!in_empty[w_search_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = w_search_idx;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_cur_queue_next = r_cur_queue;
        w_rr_ptr_next    = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_cur_queue_next = w_grant_idx;
                    w_state_next     = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (w_xfer && !w_sel_is_ctrl) begin
                    w_state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                // First control word after payload is the EOP; the finished queue
                // becomes lowest priority for the next search.
                if (w_xfer && w_sel_is_ctrl) begin
                    w_rr_ptr_next = r_cur_queue + QUEUE_BITS'(1);
                    w_state_next  = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cur_queue <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cur_queue <= w_cur_queue_next;
            r_rr_ptr    <= w_rr_ptr_next;
        end
    end

    // Output register: data/ctrl hold their last value on cycles without a transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_wr   <= 1'b0;
            r_out_data <= '0;
            r_out_ctrl <= '0;
        end else begin
            r_out_wr <= w_xfer;
            if (w_xfer) begin
                r_out_data <= w_sel_data;
                r_out_ctrl <= w_sel_ctrl;
            end
        end
    end

    assign out_wr    = r_out_wr;
    assign out_data  = r_out_data;
    assign out_ctrl  = r_out_ctrl;
    assign cur_queue = r_cur_queue;
    assign busy      = w_granted;

    a_pop_only_nonempty: assert property (@(posedge clk) disable iff (!reset_n)
        (in_rd_en & in_empty) == '0);

endmodule

// File: doc/pkt_rr_fifo_arbiter.md
Name: pkt_rr_fifo_arbiter

Overview:
- Packet-granular round-robin arbiter that drains NUM_QUEUES fallthrough small FIFOs into one registered output stream.
- Sits between per-port input FIFOs and the shared downstream pipeline stage.
- Grants one queue at a time and holds the grant until that packet's end-of-packet word has been transferred.
- Pops FIFOs through their rd_en, relying on the fallthrough property: the data is valid while empty is low.

Parameters:
- NUM_QUEUES, 4, number of requesting FIFOs; must be a power of 2 and at least 2.
- QUEUE_BITS, log2(NUM_QUEUES), width of the queue index.
- DATA_WIDTH, 64, data word width.
- CTRL_WIDTH, DATA_WIDTH/8, control word width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  NUM_QUEUES*DATA_WIDTH  FIFO dout buses; queue i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_ctrl  in  NUM_QUEUES*CTRL_WIDTH  FIFO ctrl buses, packed the same way as in_data.
- in_empty  in  NUM_QUEUES  FIFO empty flags.
- in_rd_en  out  NUM_QUEUES  per-FIFO pop; combinational, one-hot or zero.
- out_data  out  DATA_WIDTH  registered output data.
- out_ctrl  out  CTRL_WIDTH  registered output ctrl.
- out_wr  out  1  registered output write strobe.
- out_rdy  in  1  downstream can accept a word in the next cycle.
- cur_queue  out  QUEUE_BITS  index of the queue currently granted.
- busy  out  1  high while a packet is in progress (state is not IDLE).

Behaviour:
- Packet format:
  - Packet = one or more header words (ctrl != 0), then one or more payload words (ctrl == 0), then one EOP word (ctrl != 0).
  - The EOP word is the first ctrl != 0 word seen in PAYLOAD.
- Reset (reset_n low, asynchronous):
  - state = IDLE, cur_queue = 0, rr_ptr = 0.
  - out_wr = 0, out_data = 0, out_ctrl = 0, in_rd_en = 0.
  - Reset asserted mid-packet abandons the packet; no further words are popped or emitted.
- State IDLE:
  - Search queues rr_ptr, rr_ptr+1, ... modulo NUM_QUEUES.
  - The first queue with in_empty low is latched into cur_queue; go to HEADER.
  - No pop occurs in IDLE; the grant decision costs one bubble cycle.
  - If all queues are empty, stay in IDLE.
- Transfer condition (HEADER and PAYLOAD): xfer = !in_empty[cur_queue] && out_rdy.
  - in_rd_en[cur_queue] = xfer; all other bits are 0.
  - Next cycle: out_wr = 1, with out_data/out_ctrl equal to the popped word. Latency is 1 cycle from pop to out_wr.
  - Cycles without xfer: out_wr = 0, out_data/out_ctrl hold their last value, state unchanged.
- State HEADER:
  - xfer with ctrl != 0: stay in HEADER.
  - xfer with ctrl == 0: go to PAYLOAD.
- State PAYLOAD:
  - xfer with ctrl == 0: stay in PAYLOAD.
  - xfer with ctrl != 0 (EOP): rr_ptr = cur_queue+1 (wraps NUM_QUEUES-1 to 0); go to IDLE.
- Fairness:
  - After EOP, the queue that just finished has the lowest priority in the next search.
  - With all queues backlogged, grants rotate 0,1,2,3,0,...
- Empty mid-packet: the granted queue going empty stalls the transfer. The grant is held and no other queue is served.
- out_rdy low: no pop and no out_wr. The word stays at the FIFO head, since the fallthrough dout is stable.
- Simultaneous events: a queue becoming non-empty in the same cycle as EOP is considered only in the next IDLE search.
- busy = (state != IDLE). cur_queue is valid while busy.
- Sim-only check: $display an error if in_rd_en is asserted while the matching in_empty is high.

Test Plan:
- Single queue: reset_n low 2 cycles; queue 2 holds hdr ctrl=0xFF, 3 payload words, EOP ctrl=0x04 -> IDLE 1 cycle, then 5 consecutive out_wr pulses in order; cur_queue=2; busy drops after EOP; rr_ptr=3.
- All four queues each hold one 4-word packet (1 hdr, 2 payload, 1 EOP), out_rdy=1 -> grants 0,1,2,3; 16 out_wr pulses; exactly one idle bubble between packets; no words interleaved between queues.
- Backpressure: out_rdy toggles 1,0,1,0 mid-packet -> in_rd_en and out_wr asserted only on out_rdy=1 cycles; word order and count preserved.
- Granted queue's in_empty goes high for 3 cycles mid-payload while queue 1 is non-empty -> queue 1 is not served; transfer resumes on the original queue; packet delivered intact.
- rr_ptr=3 after a queue-2 EOP, queues 0 and 3 both non-empty -> queue 3 granted first, then queue 0 (wrap).
- reset_n pulsed low mid-payload of queue 1 -> out_wr=0, in_rd_en=0, busy=0 immediately (asynchronous); after release, arbitration restarts from queue 0.
